// File: rtl/mac_out_collector_pkg.sv
// mac_out_collector_pkg -- shared constants for the MAC result collector.
//
// Carries the mac_const constants: `MAC_INT_WIDTH (MAC block C width),
// the default FIFO depth and the egress width bounds. This file is
// compiled first so the macro is visible to every later file.
// Optional feature macro used by this slice: MAC_OUT_SAT_EN.

`ifndef MAC_CONST_VH
`define MAC_CONST_VH
`define MAC_INT_WIDTH 32
`endif

package mac_out_collector_pkg;

    localparam int MAC_DEFAULT_DEPTH     = 4;
    localparam int MAC_DEFAULT_OUT_WIDTH = 16;
    localparam int MAC_MIN_OUT_WIDTH     = 1;
    localparam int MAC_MAX_OUT_WIDTH     = `MAC_INT_WIDTH;

endpackage

// File: rtl/mac_out_collector_chk.sv
// mac_out_collector_chk -- protocol checker for mac_out_collector.
//
// Ports: clk, rst (active-low), capture (word written to FIFO this cycle),
// level (FIFO occupancy), mac_c (raw MAC result), word (narrowed word).
// Honours MAC_OUT_SAT_EN for the narrowing rule.

module mac_out_collector_chk #(
    parameter int  DEPTH     = 4,
    parameter int  OUT_WIDTH = 16,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input logic                      clk,
    input logic                      rst,
    input logic                      capture,
    input logic [LW-1:0]             level,
    input logic [`MAC_INT_WIDTH-1:0] mac_c,
    input logic [OUT_WIDTH-1:0]      word
);

    logic over_s;

    assign over_s = ((mac_c >> OUT_WIDTH) != '0);

    // The credit check must make a capture into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(capture && (level == LW'(DEPTH))));

`ifdef MAC_OUT_SAT_EN
    a_narrow: assert property (@(posedge clk) disable iff (!rst)
        capture |-> (word == (over_s ? {OUT_WIDTH{1'b1}} : mac_c[OUT_WIDTH-1:0])));
`else
    a_narrow: assert property (@(posedge clk) disable iff (!rst)
        capture |-> (word == mac_c[OUT_WIDTH-1:0]));
    c_truncated: cover property (@(posedge clk) disable iff (!rst)
        capture && over_s);
`endif

endmodule

// File: rtl/mac_result_fifo.sv
// mac_result_fifo -- result FIFO for the MAC output collector.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   flush              synchronous clear; wins over push and pop
//   push, push_data    write one word (caller guarantees not full)
//   pop                remove head (ignored while empty)
//   head_valid         FIFO holds at least one word
//   head_data          head word, 0 while empty
//   level              occupancy, 0..DEPTH

module mac_result_fifo
    import mac_out_collector_pkg::*;
#(
    parameter int  DEPTH     = MAC_DEFAULT_DEPTH,
    parameter int  OUT_WIDTH = MAC_DEFAULT_OUT_WIDTH,
    localparam int PW        = $clog2(DEPTH),
    localparam int LW        = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic [OUT_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic                 head_valid,
    output logic [OUT_WIDTH-1:0] head_data,
    output logic [LW-1:0]        level
);

    logic [OUT_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 do_push_s, do_pop_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Qualify push/pop: flush wins, and pop needs a word to remove.
    always_comb begin
        do_push_s = push & ~flush;
        do_pop_s  = pop & ~flush & (level_q != '0);
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; contents only matter while counted in level_q.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Head is masked while empty so stale words never leak out.
    assign head_valid = (level_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;

endmodule

// File: rtl/mac_out_collector.sv
// mac_out_collector -- collects MAC results into a credit-checked FIFO.
//
// An accepted issue sets a one-bit in-flight flag; the MAC result on mac_c
// is captured one cycle later. issue_ready only grants when the FIFO has a
// slot for every result already buffered or in flight, so the FIFO can
// never overflow.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   issue_valid/ready     issue handshake; mac_en = issue_valid & issue_ready
//   mac_c                 MAC block C output (`MAC_INT_WIDTH bits, unsigned)
//   flush                 synchronous clear of FIFO, in-flight state, ovf
//   out_valid/ready/data  egress handshake, OUT_WIDTH-bit head word
//   ovf                   sticky saturation flag
//   level                 FIFO occupancy
// Config: define MAC_OUT_SAT_EN to saturate wide results (and flag ovf);
// otherwise results are truncated and ovf is 0.

module mac_out_collector
    import mac_out_collector_pkg::*;
#(
    parameter int  DEPTH     = MAC_DEFAULT_DEPTH,
    parameter int  OUT_WIDTH = MAC_DEFAULT_OUT_WIDTH,
    localparam int LW        = $clog2(DEPTH) + 1,
    localparam int CW        = LW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    output logic                      mac_en,
    input  logic [`MAC_INT_WIDTH-1:0] mac_c,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      ovf,
    output logic [LW-1:0]             level
);

    logic                 run_q, run_d;
    logic                 inflight_q, inflight_d;
    logic                 issue_fire_s, capture_s, pop_s;
    logic [CW-1:0]        credit_s;
    logic [OUT_WIDTH-1:0] word_s;

    // Credit check: grant only when buffered + in-flight leaves a free slot.
    // run_q keeps issue_ready low until the first edge after reset release.
    always_comb begin
        credit_s     = {1'b0, level} + {{LW{1'b0}}, inflight_q};
        issue_ready  = run_q & ~flush & (credit_s < CW'(DEPTH));
        issue_fire_s = issue_valid & issue_ready;
        capture_s    = inflight_q & ~flush;
        pop_s        = out_valid & out_ready;
    end

    assign mac_en = issue_fire_s;

    // In-flight and run next-state; flush drops any pending result.
    always_comb begin
        run_d = 1'b1;
        if (flush) begin
            inflight_d = 1'b0;
        end else begin
            inflight_d = issue_fire_s;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            run_q      <= run_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef MAC_OUT_SAT_EN
    logic over_s;
    logic ovf_q, ovf_d;

    // Saturating narrow: any bit above the egress width forces all-ones.
    always_comb begin
        over_s = ((mac_c >> OUT_WIDTH) != '0);
        if (over_s) begin
            word_s = {OUT_WIDTH{1'b1}};
        end else begin
            word_s = mac_c[OUT_WIDTH-1:0];
        end
    end

    // Sticky saturation flag, cleared only by flush or reset.
    always_comb begin
        if (flush) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (capture_s & over_s);
        end
    end

    // Saturation flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Truncating narrow: keep the low egress bits, never flag.
    always_comb begin
        word_s = mac_c[OUT_WIDTH-1:0];
    end

    assign ovf = 1'b0;
`endif

    mac_result_fifo #(
        .DEPTH     (DEPTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (capture_s),
        .push_data  (word_s),
        .pop        (pop_s),
        .head_valid (out_valid),
        .head_data  (out_data),
        .level      (level)
    );

    mac_out_collector_chk #(
        .DEPTH     (DEPTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .capture (capture_s),
        .level   (level),
        .mac_c   (mac_c),
        .word    (word_s)
    );

endmodule

// File: tb/tb_mac_out_collector.sv
// tb_mac_out_collector -- self-checking bench for mac_out_collector.
//
// A queue-based reference model (expected FIFO contents, one pending-result
// flag, sticky ovf) is advanced once per clock from the handshake rules and
// compared with the DUT every cycle; directed scenarios add targeted checks.

`ifndef MAC_INT_WIDTH
`define MAC_INT_WIDTH 32
`endif

module tb_mac_out_collector;

    localparam int DEPTH = 4;
    localparam int OW    = 16;
    localparam int IW    = `MAC_INT_WIDTH;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef MAC_OUT_SAT_EN
    localparam bit SAT   = 1'b1;
`else
    localparam bit SAT   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic          issue_ready;
    logic          mac_en;
    logic [IW-1:0] mac_c;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          ovf;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    mac_out_collector #(
        .DEPTH     (DEPTH),
        .OUT_WIDTH (OW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .mac_en      (mac_en),
        .mac_c       (mac_c),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .ovf         (ovf),
        .level       (level)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          en_count = 0;
    logic [OW-1:0] exp_q[$];
    bit          m_inflight = 1'b0;
    bit          m_ovf      = 1'b0;
    bit          m_started  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference narrowing in plain arithmetic on the unsigned value.
    function automatic bit is_wide(input logic [IW-1:0] c);
        longint unsigned v = longint'(c);
        return v >= (64'd1 << OW);
    endfunction

    function automatic logic [OW-1:0] narrow(input logic [IW-1:0] c);
        longint unsigned v = longint'(c);
        longint unsigned m = (64'd1 << OW);
        if (SAT && is_wide(c)) return OW'(m - 1);
        return OW'(v % m);
    endfunction

    function automatic bit model_ready(input bit fl);
        return m_started && !fl && ((exp_q.size() + int'(m_inflight)) < DEPTH);
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".out_valid"}, out_valid, exp_q.size() > 0);
        check({tag, ".level"}, level, exp_q.size());
        check({tag, ".ovf"}, ovf, m_ovf);
        if (exp_q.size() > 0) check({tag, ".out_data"}, out_data, exp_q[0]);
    endtask

    // One clock: drive at the negedge, check combinational grant, advance
    // the model at the posedge, check registered state at the next negedge.
    task automatic cycle(input bit iv, input bit fl, input bit ordy, input logic [IW-1:0] c);
        bit rdy;
        bit fire;
        issue_valid = iv;
        flush       = fl;
        out_ready   = ordy;
        mac_c       = c;
        #1;
        rdy  = model_ready(fl);
        fire = iv && rdy;
        check("issue_ready", issue_ready, rdy);
        check("mac_en", mac_en, fire);
        if (mac_en) en_count++;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            m_inflight = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            if (ordy && exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_inflight) begin
                exp_q.push_back(narrow(c));
                if (SAT && is_wide(c)) m_ovf = 1'b1;
            end
            m_inflight = fire;
        end
        m_started = 1'b1;
        @(negedge clk);
        check_state("cyc");
    endtask

    task automatic reset_check(input string tag);
        rst         = 1'b0;
        issue_valid = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b1;
        exp_q.delete();
        m_inflight  = 1'b0;
        m_ovf       = 1'b0;
        m_started   = 1'b0;
        #1;
        check({tag, ".out_valid"}, out_valid, 1'b0);
        check({tag, ".level"}, level, 0);
        check({tag, ".ovf"}, ovf, 1'b0);
        check({tag, ".out_data"}, out_data, 0);
        check({tag, ".issue_ready"}, issue_ready, 1'b0);
        check({tag, ".mac_en"}, mac_en, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check({tag, ".hold_level"}, level, 0);
        check({tag, ".hold_issue_ready"}, issue_ready, 1'b0);
        issue_valid = 1'b0;
        rst         = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    endtask

    initial begin
        rst         = 1'b0;
        issue_valid = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        mac_c       = '0;
        @(negedge clk);
        reset_check("reset");

        // First edge after release raises issue_ready.
        cycle(1'b1, 1'b0, 1'b1, '0);
        check("ready_after_release", issue_ready, 1'b1);

        // Single issue, result one cycle later, visible two cycles after.
        cycle(1'b1, 1'b0, 1'b0, IW'(32'h0000_0000));
        check("single.not_yet", out_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, IW'(32'h0000_1234));
        check("single.out_valid", out_valid, 1'b1);
        check("single.out_data", out_data, 16'h1234);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("single.level_back", level, 0);

        // Back-to-back issues against a stalled consumer.
        en_count = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, IW'(100 + i));
        check("stall.en_pulses", en_count, 4);
        check("stall.level_full", level, DEPTH);
        check("stall.out_data_hold", out_data, 16'd101);
        cycle(1'b1, 1'b0, 1'b1, IW'(200));
        check("stall.no_issue_on_pop", en_count, 4);
        cycle(1'b1, 1'b0, 1'b0, IW'(201));
        check("stall.fifth_issue", en_count, 5);
        drain(8);

        // Steady stream: one result per cycle, order kept, level <= 1.
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0, 1'b1, IW'(i));
            check("stream.level_le1", level <= LW'(1), 1'b1);
        end
        drain(3);

        // Wide result: saturate and flag, or truncate.
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, IW'(32'h0001_0005));
        check("narrow.out_data", out_data, SAT ? 16'hFFFF : 16'h0005);
        check("narrow.ovf", ovf, SAT);
        drain(2);

        // Flush one cycle after an issue with level 2; in-flight lost.
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, IW'(32'h0002_0000));
        cycle(1'b0, 1'b0, 1'b0, IW'(32'h0000_0042));
        check("flush.level_before", level, 2);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, IW'(32'h0000_BEEF));
        check("flush.level", level, 0);
        check("flush.ovf", ovf, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("flush.no_stale", out_valid, 1'b0);

        // Reset mid-operation with level 3 and one result in flight.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, IW'(300 + i));
        check("midrst.level_before", level, 3);
        reset_check("midrst");
        cycle(1'b0, 1'b0, 1'b1, IW'(32'h0000_0777));
        check("midrst.no_stale", out_valid, 1'b0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            logic [IW-1:0] c;
            c = IW'($urandom);
            if ($urandom_range(0, 1) == 0) c = c & IW'(32'h0000_FFFF);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 2) != 0, c);
        end
        drain(8);
        check("end.level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_out_collector.md
MAC_OUT_COLLECTOR -- requirements
Module: mac_out_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4; result FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter OUT_WIDTH, default 16; egress word width, at most `MAC_INT_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port issue_valid  input  1  upstream requests a MAC issue this cycle.
REQ-006 SHALL have port issue_ready  output  1  collector can accept the issued result; issue happens when issue_valid and issue_ready are both high.
REQ-007 SHALL have port mac_en  output  1  drives MAC block en; equals issue_valid AND issue_ready.
REQ-008 SHALL have port mac_c  input  `MAC_INT_WIDTH  MAC block C output.
REQ-009 SHALL have port flush  input  1  synchronous clear of FIFO, in-flight state and flags.
REQ-010 SHALL have port out_valid  output  1  FIFO head valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the head.
REQ-012 SHALL have port out_data  output  OUT_WIDTH  FIFO head word.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag.
REQ-014 SHALL have port level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-015 Issue at cycle t SHALL set a 1-bit in-flight register, so the result on mac_c is captured into the FIFO at the end of cycle t+1 (MAC registered latency 1).
REQ-016 Earliest out_valid for an issue at cycle t SHALL be cycle t+2.
REQ-017 issue_ready SHALL be (level + inflight) < DEPTH, derived only from registers.
REQ-018 Overflow of the FIFO SHALL be impossible by construction; assertion: no capture while level == DEPTH.
REQ-019 A pop SHALL occur when out_valid and out_ready are high; out_data SHALL be held stable while out_valid is high and out_ready is low.
REQ-020 Capture and pop in the same cycle SHALL leave level unchanged; at level 0 the captured word SHALL appear on the following cycle, with no bypass.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 Narrowing SHALL treat mac_c as unsigned; bits above OUT_WIDTH SHALL be handled per REQ-027/028.
REQ-023 flush SHALL take priority over capture, pop and issue in the same cycle: level becomes 0, inflight becomes 0, ovf becomes 0, and issue_ready is low during the flush cycle.
REQ-024 An in-flight result that arrives in the cycle after a flush SHALL be discarded.

Reset
REQ-025 While rst is low: out_valid=0, level=0, ovf=0, inflight=0, pointers=0, issue_ready=0, mac_en=0; out_data is 0.
REQ-026 Reset mid-operation SHALL discard buffered and in-flight results; issue_ready SHALL rise on the first clock edge after rst deasserts.

Configuration
REQ-027 With MAC_OUT_SAT_EN defined: a captured word with any nonzero bit above OUT_WIDTH-1 SHALL be stored as all-ones and SHALL set ovf until flush or reset.
REQ-028 Without MAC_OUT_SAT_EN: the word SHALL be truncated to its low OUT_WIDTH bits, and ovf SHALL be tied to 0.

Structure
REQ-029 OUT_WIDTH bounds checks and the default DEPTH SHALL live as constants in mac_const.vh, alongside `MAC_INT_WIDTH.
REQ-030 The FIFO storage and pointers SHALL be one sub-module, mac_result_fifo (DEPTH, OUT_WIDTH, push, pop, flush, level).
REQ-031 The in-flight tracking, credit check and narrowing SHALL remain in mac_out_collector.

Verification
REQ-032 Single issue with mac_c=0x0000_1234 one cycle later and out_ready=1 -> out_valid high two cycles after the issue, out_data=0x1234, level returns to 0.
REQ-033 out_ready=0 with 6 back-to-back issues, DEPTH=4 -> exactly 4 mac_en pulses, issue_ready low with level=4; the 5th issue occurs the cycle after the first pop.
REQ-034 Steady stream with out_ready=1 -> one result per cycle, level stays at or below 1, order preserved (1,2,3,...).
REQ-035 mac_c=0x0001_0005 with OUT_WIDTH=16 -> out_data=0xFFFF and ovf=1 with MAC_OUT_SAT_EN; out_data=0x0005 and ovf=0 without it.
REQ-036 Flush asserted the cycle after an issue, with level=2 -> level=0 next cycle, the in-flight result is never output, and ovf is cleared.
REQ-037 rst pulled low with level=3 and one result in flight -> all outputs at reset values immediately, no stale data after release.
